// File: rtl/i2c_reg_target_if.sv
// Register-bus interface between the I2C target and the register file.
//   reg_addr   register pointer presented with a strobe
//   reg_wdata  write data, valid with reg_wr_en
//   reg_wr_en  one-clk write strobe
//   reg_rd_en  one-clk read strobe
//   reg_rdata  read data from the register file, one clk after reg_rd_en
// master: the I2C target side; slave: the register file side.
`timescale 1ns/1ps
interface i2c_reg_target_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_wr_en,
    output reg_rd_en,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr_en,
    input  reg_rd_en,
    output reg_rdata
  );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C target that bridges SCL/SDA pads onto a single-cycle register bus.
// Decodes a 7-bit device address, loads an 8-bit register pointer from the
// first written byte, then turns each further byte into a register write or
// read with pointer auto-increment (wraps 8'hFF -> 8'h00, kept across
// transactions).
//   clk, rst  system clock, synchronous active-high reset
//   scl_i     raw SCL pad (asynchronous)
//   sda_i     raw SDA pad (asynchronous)
//   sda_oe    1 = pull SDA low (open drain)
//   busy      high from matched-address START until STOP/abort
//   bus       register bus (i2c_reg_target_if.master)
// Optional macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter
// on SCL and SDA after the synchronizers (rejects 1-clk pulses, +1 clk).
`timescale 1ns/1ps
module i2c_reg_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h55
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  i2c_reg_target_if.master bus
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  // Pad synchronizers. Left out of reset so a reset mid-transaction cannot
  // fabricate SDA/SCL edges when the pipeline refills.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f;
  logic       scl_d, sda_d;

  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[0], scl_i};
    sda_sync <= {sda_sync[0], sda_i};
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  // Majority of the current synchronized sample and the two before it.
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk) begin
    scl_hist <= {scl_hist[0], scl_sync[1]};
    sda_hist <= {sda_hist[0], sda_sync[1]};
  end

  assign scl_f = (scl_hist[1] & scl_hist[0]) | (scl_hist[1] & scl_sync[1]) |
                 (scl_hist[0] & scl_sync[1]);
  assign sda_f = (sda_hist[1] & sda_hist[0]) | (sda_hist[1] & sda_sync[1]) |
                 (sda_hist[0] & sda_sync[1]);
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  // Edge and bus-condition detection on the conditioned copies.
  always_ff @(posedge clk) begin
    scl_d <= scl_f;
    sda_d <= sda_f;
  end

  logic scl_rise_c, scl_fall_c, start_c, stop_c;
  assign scl_rise_c = scl_f & ~scl_d;
  assign scl_fall_c = ~scl_f & scl_d;
  assign start_c    = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c     = scl_f & scl_d & ~sda_d & sda_f;

  // Registered state.
  state_t             state, state_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [6:0]         shreg, shreg_n;
  logic               rw, rw_n;
  logic               ack_on, ack_on_n;
  logic [BYTE_W-1:0]  ptr, ptr_n;
  logic [BYTE_W-1:0]  tx, tx_n;
  logic               rd_dly;
  logic               sda_oe_n, busy_n;
  logic [BYTE_W-1:0]  reg_addr, reg_addr_n;
  logic [BYTE_W-1:0]  reg_wdata, reg_wdata_n;
  logic               reg_wr_en, reg_wr_en_n;
  logic               reg_rd_en, reg_rd_en_n;
  logic [BYTE_W-1:0]  byte_c;

  assign byte_c        = {shreg, sda_f};
  assign bus.reg_addr  = reg_addr;
  assign bus.reg_wdata = reg_wdata;
  assign bus.reg_wr_en = reg_wr_en;
  assign bus.reg_rd_en = reg_rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      ptr       <= '0;
      tx        <= '0;
      rd_dly    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      rw        <= rw_n;
      ack_on    <= ack_on_n;
      ptr       <= ptr_n;
      tx        <= tx_n;
      rd_dly    <= reg_rd_en;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
      reg_wr_en <= reg_wr_en_n;
      reg_rd_en <= reg_rd_en_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    rw_n        = rw;
    ack_on_n    = ack_on;
    ptr_n       = ptr;
    // Read data arrives one clk after the read strobe.
    tx_n        = rd_dly ? bus.reg_rdata : tx;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    reg_wr_en_n = 1'b0;
    reg_rd_en_n = 1'b0;

    if (stop_c) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_c) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          sda_oe_n = 1'b0;
        end

        ST_ADDR: begin
          if (scl_rise_c) begin
            shreg_n   = byte_c[6:0];
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              if (shreg == TARGET_ADDR) begin
                state_n  = ST_ADDR_ACK;
                rw_n     = sda_f;
                ack_on_n = 1'b0;
                busy_n   = 1'b1;
                if (sda_f) begin
                  reg_rd_en_n = 1'b1;
                  reg_addr_n  = ptr;
                  ptr_n       = BYTE_W'(ptr + BYTE_W'(1));
                end
              end else begin
                state_n = ST_WAIT_STOP;
                busy_n  = 1'b0;
              end
            end
          end
        end

        // ACK slot: drive low on the first SCL fall, release on the second.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_c) begin
            if (!ack_on) begin
              ack_on_n = 1'b1;
              sda_oe_n = 1'b1;
            end else begin
              ack_on_n  = 1'b0;
              bit_cnt_n = '0;
              sda_oe_n  = 1'b0;
              if (state == ST_ADDR_ACK) begin
                if (rw) begin
                  state_n  = ST_RDATA;
                  sda_oe_n = ~tx[7];
                end else begin
                  state_n = ST_PTR;
                end
              end else begin
                state_n = ST_WDATA;
              end
            end
          end
        end

        ST_PTR: begin
          if (scl_rise_c) begin
            shreg_n   = byte_c[6:0];
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              ptr_n    = byte_c;
              state_n  = ST_PTR_ACK;
              ack_on_n = 1'b0;
            end
          end
        end

        ST_WDATA: begin
          if (scl_rise_c) begin
            shreg_n   = byte_c[6:0];
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              reg_wr_en_n = 1'b1;
              reg_addr_n  = ptr;
              reg_wdata_n = byte_c;
              ptr_n       = BYTE_W'(ptr + BYTE_W'(1));
              state_n     = ST_WDATA_ACK;
              ack_on_n    = 1'b0;
            end
          end
        end

        // MSB already driven on entry; each later SCL fall presents the next bit.
        ST_RDATA: begin
          if (scl_rise_c) begin
            bit_cnt_n = CNT_W'(bit_cnt + CNT_W'(1));
            if (bit_cnt == CNT_W'(7)) begin
              state_n  = ST_RDATA_ACK;
              ack_on_n = 1'b0;
            end
          end else if (scl_fall_c) begin
            tx_n     = {tx[6:0], 1'b0};
            sda_oe_n = ~tx[6];
          end
        end

        // ack_on marks that the initiator's ACK has been sampled.
        ST_RDATA_ACK: begin
          if (scl_rise_c) begin
            if (sda_f) begin
              state_n  = ST_WAIT_STOP;
              sda_oe_n = 1'b0;
            end else begin
              reg_rd_en_n = 1'b1;
              reg_addr_n  = ptr;
              ptr_n       = BYTE_W'(ptr + BYTE_W'(1));
              ack_on_n    = 1'b1;
            end
          end else if (scl_fall_c) begin
            if (ack_on) begin
              ack_on_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = ST_RDATA;
              sda_oe_n  = ~tx[7];
            end else begin
              sda_oe_n = 1'b0;
            end
          end
        end

        ST_WAIT_STOP: begin
          sda_oe_n = 1'b0;
        end

        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule
